// File: rtl/fpga_cfg_pkg.sv
// Shared fixed-point and shared-math-unit configuration.
// Imported by the exp LUT arbiter and its tag FIFO.
package fpga_cfg_pkg;

    localparam int FP_WIDTH          = 32;
    localparam int QFRAC             = 16;
    localparam int EXP_ARB_N_REQ     = 4;
    localparam int EXP_ARB_TAG_DEPTH = 4;

    typedef logic [$clog2(EXP_ARB_N_REQ)-1:0] req_id_t;

endpackage

// File: rtl/rr_tag_fifo.sv
// In-order tag FIFO for shared math units (exp, div, sqrt).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rr_tag_fifo
    import fpga_cfg_pkg::*;
#(
    parameter type T     = req_id_t,
    parameter int  DEPTH = EXP_ARB_TAG_DEPTH
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_push,
    input  T     i_din,
    input  logic i_pop,
    output T     o_dout,
    output logic o_full,
    output logic o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] r_wr;
    logic [AW:0] r_rd;
    T            r_mem [DEPTH];

    assign o_empty = (r_wr == r_rd);
    assign o_full  = (r_wr[AW] != r_rd[AW]) &&
                     (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign o_dout  = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + 1'b1;
            if (i_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end

    a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_push && o_full && !i_pop));
    a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
        !(i_pop && o_empty));

endmodule

// File: rtl/exp_lut_arbiter.sv
// Round-robin arbiter sharing one exp LUT unit between N_REQ requesters.
// Issued requester IDs are queued in order so each result returns to its owner.
module exp_lut_arbiter
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH     = FP_WIDTH,
    parameter int N_REQ     = EXP_ARB_N_REQ,
    parameter int TAG_DEPTH = EXP_ARB_TAG_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    output logic                   exp_valid,
    input  logic                   exp_ready,
    output logic [WIDTH-1:0]       exp_a,
    input  logic                   exp_res_valid,
    output logic                   exp_res_ready,
    input  logic [WIDTH-1:0]       exp_result,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   busy,
    output logic [31:0]            stall_cnt
);

    localparam int IDW = $clog2(N_REQ);
    typedef logic [IDW-1:0] id_t;

    id_t              r_ptr;
    id_t              r_lock_g;
    logic             r_lock;
    logic [WIDTH-1:0] r_lock_a;
    logic [31:0]      r_stall;

    id_t              w_idx;
    id_t              w_cand;
    id_t              w_grant;
    id_t              w_head;
    logic             w_found;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_issue_ok;
    logic             w_stall;
    logic [WIDTH-1:0] w_opd [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_opd
        assign w_opd[i] = req_a[i*WIDTH +: WIDTH];
    end

    // First valid requester at or after r_ptr, wrapping.
    always_comb begin
        w_found = 1'b0;
        w_cand  = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = id_t'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_cand  = w_idx;
            end
        end
    end

    assign w_pop      = exp_res_valid && exp_res_ready;
    assign w_issue_ok = !w_full || w_pop;
    assign w_grant    = r_lock ? r_lock_g : w_cand;
    assign exp_valid  = !rst && (r_lock || (w_found && w_issue_ok));
    assign exp_a      = r_lock ? r_lock_a : w_opd[w_cand];
    assign w_push     = exp_valid && exp_ready;
    assign w_stall    = exp_valid && !exp_ready;
    assign req_ready  = w_push ? (N_REQ'(1) << w_grant) : '0;

    assign exp_res_ready = !w_empty && rsp_ready[w_head];
    assign rsp_valid     = (exp_res_valid && !w_empty) ?
                           (N_REQ'(1) << w_head) : '0;
    assign rsp_data      = exp_result;
    assign busy          = !w_empty;
    assign stall_cnt     = r_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_lock   <= 1'b0;
            r_lock_g <= '0;
            r_lock_a <= '0;
            r_stall  <= '0;
        end else begin
            if (w_push) begin
                r_ptr <= (w_grant == id_t'(N_REQ-1)) ? '0 : w_grant + 1'b1;
            end
            r_lock <= w_stall;
            if (w_stall) begin
                r_lock_g <= w_grant;
                r_lock_a <= exp_a;
                if (r_stall != '1) r_stall <= r_stall + 32'd1;
            end
        end
    end

    rr_tag_fifo #(
        .T     (id_t),
        .DEPTH (TAG_DEPTH)
    ) u_tags (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_din   (w_grant),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    a_hold: assert property (@(posedge clk) disable iff (rst)
        w_stall |=> ($stable(exp_a) && $stable(w_grant)));
    a_rsp_onehot0: assert property (@(posedge clk) disable iff (rst)
        $onehot0(rsp_valid));
    a_res_no_tag: assert property (@(posedge clk) disable iff (rst)
        !(exp_res_valid && w_empty));

endmodule
